// File: rtl/systolic_input_feeder.sv
// Skews activation vectors into a systolic array: lane r of each accepted beat leaves r+1 cycles later.
// Optional 16-bit accepted-beat counter on port beat_count, enabled by macro FEEDER_BEAT_COUNT_EN.
module systolic_input_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] act_out,
    output logic [ROWS-1:0]            act_valid,
    output logic                       busy,
`ifdef FEEDER_BEAT_COUNT_EN
    output logic [15:0]                beat_count,
`endif
    output logic                       done
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | accepting beats until in_last
    // DRAIN  | ROWS cycles for the skew pipeline to empty
    // DONE   | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int CW = $clog2(ROWS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign accept    = in_valid && (state_q == STREAM);
    assign in_ready  = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (start) state_d = STREAM;
            STREAM: if (accept && in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(ROWS - 1);
                    end
            DRAIN:  if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - CW'(1);
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane r is a chain of r+1 registers; non-accept cycles shift in zero bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] data_q [0:r];
        logic [r:0]            vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
                for (int k = 0; k <= r; k++) data_q[k] <= '0;
            end else begin
                vld_q[0]  <= accept;
                data_q[0] <= accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= r; k++) begin
                    vld_q[k]  <= vld_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end

        assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
        assign act_valid[r]                        = vld_q[r];
    end

`ifdef FEEDER_BEAT_COUNT_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  beat_cnt_q <= '0;
        else if (state_q == IDLE && start)          beat_cnt_q <= '0;
        else if (accept && beat_cnt_q != 16'hFFFF)  beat_cnt_q <= beat_cnt_q + 16'd1;
    end

    assign beat_count = beat_cnt_q;
`endif

endmodule

// File: doc/systolic_input_feeder.md
SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set activation lane width in bits.
REQ-002 Parameter ROWS, default 4, minimum 2, SHALL set the number of array rows fed.
REQ-003 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a stream.
REQ-006 in_valid  input  1  SHALL mark in_data/in_last as valid.
REQ-007 in_ready  output  1  SHALL indicate the feeder accepts a beat this cycle.
REQ-008 in_data  input  ROWS*DATA_WIDTH  SHALL carry one activation vector; lane r = bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_last  input  1  SHALL mark the final beat of the stream.
REQ-010 act_out  output  ROWS*DATA_WIDTH  SHALL carry the skewed activations; lane r drives the input_in of array row r, column 0.
REQ-011 act_valid  output  ROWS  SHALL carry per-row valid; bit r drives the valid of row r, column 0.
REQ-012 busy  output  1  SHALL be high in any state other than IDLE.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle when the stream has fully drained.

Function
REQ-014 The FSM SHALL have states IDLE, STREAM, DRAIN, DONE.
REQ-015 IDLE->STREAM on start=1; start in any other state SHALL be ignored.
REQ-016 in_ready SHALL be 1 only in STREAM; a beat is accepted when in_valid && in_ready.
REQ-017 Accepting a beat with in_last=1 SHALL move STREAM->DRAIN on the next edge.
REQ-018 DRAIN SHALL last exactly ROWS cycles, counted by an internal counter, then move to DONE.
REQ-019 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-020 Lane r of an accepted beat SHALL appear on act_out lane r exactly r+1 cycles after the accepting edge, with act_valid[r]=1 in that cycle.
REQ-021 A STREAM cycle without an accepted beat SHALL inject a bubble: act_valid[r]=0 and act_out lane r=0 at the matching skewed slot.
REQ-022 Whenever act_valid[r]=0, act_out lane r SHALL be 0.
REQ-023 Data SHALL pass unmodified; no arithmetic or width change.
REQ-024 After the last beat, all act_valid bits SHALL be 0 by the cycle done is asserted.
REQ-025 A single-beat stream (in_last on first beat) SHALL be legal and follow REQ-017..REQ-019.

Reset
REQ-026 On reset: state=IDLE, all skew registers=0, act_out=0, act_valid=0, in_ready=0, busy=0, done=0.
REQ-027 Reset asserted mid-stream or mid-drain SHALL discard all in-flight data, with no done pulse.

Configuration
REQ-028 Macro FEEDER_BEAT_COUNT_EN, when defined, SHALL add output beat_count (16 bits): cleared on reset and on start acceptance, incremented per accepted beat, saturating at 0xFFFF, held until the next start.
REQ-029 Without FEEDER_BEAT_COUNT_EN, the beat_count port and its counter SHALL NOT exist; all other behaviour is identical.

Verification (ROWS=4, DATA_WIDTH=16)
REQ-030 Reset then idle 5 cycles -> act_valid=0000, in_ready=0, busy=0, done=0 throughout.
REQ-031 start, then beats lanes {1,2,3,4},{5,6,7,8} with last on the second beat -> lane0=1,5 at +1,+2; lane3=4,8 at +4,+5; done one cycle after DRAIN (4 cycles).
REQ-032 in_valid low for one cycle between two beats -> one-cycle zero/invalid gap at each lane, skewed by r.
REQ-033 Single beat {A,B,C,D} with last -> act_valid pattern 0001,0010,0100,1000 on consecutive cycles; done follows.
REQ-034 reset asserted during DRAIN -> outputs zero immediately, no done, next start works normally.
REQ-035 With FEEDER_BEAT_COUNT_EN, 3 beats accepted -> beat_count=3 at done; a second start clears it to 0.
